// File: rtl/udp_payload_sched.sv
// Multi-channel payload scheduler for the UDP transmit engine: per-channel snapshot queueing,
// round-robin packet launch with optional header word, MSB-first word serialization, gap and timeout.
module udp_payload_sched #(
    parameter int NUM_CH       = 4,
    parameter int PAYLOAD_BITS = 88,
    parameter int HDR_EN       = 1,
    parameter int GAP_CYCLES   = 12,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0] i_ch_payload,
    input  logic [NUM_CH-1:0]              i_ch_trigger,
    output logic                           o_tx_start_en,
    output logic [15:0]                    o_tx_byte_num,
    output logic [31:0]                    o_tx_data,
    input  logic                           i_tx_req,
    input  logic                           i_tx_done,
    output logic                           o_busy,
    output logic [NUM_CH-1:0]              o_ch_drop,
    output logic [15:0]                    o_drop_cnt,
    output logic                           o_timeout_err
);

    localparam int PAYLOAD_BYTES = (PAYLOAD_BITS + 7) / 8;
    localparam int HDR_BITS      = (HDR_EN != 0) ? 32 : 0;
    localparam int BYTE_NUM      = PAYLOAD_BYTES + HDR_BITS / 8;
    localparam int WORDS         = (BYTE_NUM + 3) / 4;
    localparam int BUF_BITS      = WORDS * 32;
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W         = $clog2(WORDS + 1);
    localparam int TMO_W         = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W         = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]              r_state;
    logic [NUM_CH-1:0]       r_pending;
    logic [PAYLOAD_BITS-1:0] r_snap [NUM_CH];
    logic [NUM_CH-1:0][15:0] r_seq;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [31:0]             r_buf [WORDS];
    logic [IDX_W-1:0]        r_word_idx;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [15:0]             r_drop_cnt;
    logic [NUM_CH-1:0]       r_ch_drop;
    logic                    r_timeout_err;
    logic [31:0]             r_tx_data;

    logic                    w_grant_vld;
    logic [CH_W-1:0]         w_grant_id;
    logic [CH_W-1:0]         w_cand;
    logic [NUM_CH-1:0]       w_grant_oh;
    logic [NUM_CH-1:0]       w_drop;
    logic [16:0]             w_drop_sum;
    logic [BUF_BITS-1:0]     w_buf;
    logic [IDX_W-1:0]        w_sel;
    logic [31:0]             w_word;

    // Descending scan so the nearest pending channel after r_rr_ptr is the last one written.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            if (r_pending[w_cand]) begin
                w_grant_vld = (r_state == ST_IDLE);
                w_grant_id  = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_grant_vld) begin
            w_grant_oh[w_grant_id] = 1'b1;
        end
        w_drop     = i_ch_trigger & r_pending & ~w_grant_oh;
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int c = 0; c < NUM_CH; c++) begin
            w_drop_sum = w_drop_sum + 17'(w_drop[c]);
        end
    end

    always_comb begin
        w_buf = '0;
        if (HDR_EN != 0) begin
            w_buf[BUF_BITS-1 -: 32] = {8'hA5, 4'h0, 4'(w_grant_id), r_seq[w_grant_id]};
        end
        w_buf[BUF_BITS-1-HDR_BITS -: PAYLOAD_BITS] = r_snap[w_grant_id];
    end

    // Requests beyond the last word keep re-reading the last word.
    always_comb begin
        w_sel  = (r_word_idx >= IDX_W'(WORDS)) ? IDX_W'(WORDS - 1) : r_word_idx;
        w_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (w_sel == IDX_W'(w)) begin
                w_word = r_buf[w];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= '0;
            r_ch_drop  <= '0;
            r_drop_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_snap[c] <= '0;
            end
        end else begin
            // A granted channel hands its old snapshot to the buffer and may recapture at once.
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_ch_trigger[c] && (!r_pending[c] || w_grant_oh[c])) begin
                    r_snap[c]    <= i_ch_payload[c*PAYLOAD_BITS +: PAYLOAD_BITS];
                    r_pending[c] <= 1'b1;
                end else if (w_grant_oh[c]) begin
                    r_pending[c] <= 1'b0;
                end
            end
            r_ch_drop  <= w_drop;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_seq         <= '0;
            r_rr_ptr      <= CH_W'(NUM_CH - 1);
            r_word_idx    <= '0;
            r_tmo_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
            for (int w = 0; w < WORDS; w++) begin
                r_buf[w] <= '0;
            end
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        for (int w = 0; w < WORDS; w++) begin
                            r_buf[w] <= w_buf[BUF_BITS-1-32*w -: 32];
                        end
                        r_seq[w_grant_id] <= r_seq[w_grant_id] + 16'd1;
                        r_rr_ptr          <= w_grant_id;
                        r_word_idx        <= '0;
                        r_state           <= ST_START;
                    end
                end
                ST_START: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_tx_req) begin
                        r_tx_data <= w_word;
                        if (r_word_idx < IDX_W'(WORDS)) begin
                            r_word_idx <= r_word_idx + IDX_W'(1);
                        end
                    end
                    if (i_tx_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_gap_cnt     <= '0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_start_en = (r_state == ST_START);
    assign o_tx_byte_num = 16'(BYTE_NUM);
    assign o_tx_data     = r_tx_data;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_ch_drop     = r_ch_drop;
    assign o_drop_cnt    = r_drop_cnt;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_udp_payload_sched.sv
// Scoreboard bench for udp_payload_sched: expected words are queued at stimulus time and a forked
// monitor checks each word the DUT returns after a tx_req.
module tb_udp_payload_sched;

    localparam int NCH = 2;
    localparam int PB  = 88;
    localparam int GAP = 12;
    localparam int TMO = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*PB-1:0] ch_payload;
    logic [NCH-1:0]    ch_trigger;
    logic              tx_start_en;
    logic [15:0]       tx_byte_num;
    logic [31:0]       tx_data;
    logic              tx_req;
    logic              tx_done;
    logic              busy;
    logic [NCH-1:0]    ch_drop;
    logic [15:0]       drop_cnt;
    logic              timeout_err;

    udp_payload_sched #(
        .NUM_CH       (NCH),
        .PAYLOAD_BITS (PB),
        .HDR_EN       (1),
        .GAP_CYCLES   (GAP),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ch_payload  (ch_payload),
        .i_ch_trigger  (ch_trigger),
        .o_tx_start_en (tx_start_en),
        .o_tx_byte_num (tx_byte_num),
        .o_tx_data     (tx_data),
        .i_tx_req      (tx_req),
        .i_tx_done     (tx_done),
        .o_busy        (busy),
        .o_ch_drop     (ch_drop),
        .o_drop_cnt    (drop_cnt),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_start = 0;
    int          n_drop0 = 0;
    int          n_drop1 = 0;
    int          n_tmo = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic r;
        forever begin
            @(posedge clk);
            r = tx_req;
            @(negedge clk);
            if (r && rst_n) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic counters();
        forever begin
            @(negedge clk);
            if (tx_start_en) n_start++;
            if (ch_drop[0]) n_drop0++;
            if (ch_drop[1]) n_drop1++;
            if (timeout_err) n_tmo++;
        end
    endtask

    task automatic push_pkt(input int ch, input logic [15:0] seq, input logic [PB-1:0] p,
                            input int n);
        logic [31:0] w [4];
        w[0] = {8'hA5, 4'h0, 4'(ch), seq};
        w[1] = p[87:56];
        w[2] = p[55:24];
        w[3] = {p[23:0], 8'h00};
        for (int i = 0; i < n; i++) exp_q.push_back(w[(i < 4) ? i : 3]);
    endtask

    task automatic trig(input logic [1:0] m, input logic [PB-1:0] p0, input logic [PB-1:0] p1,
                        output int t);
        @(negedge clk);
        ch_payload = {p1, p0};
        ch_trigger = m;
        t = cyc;
        @(negedge clk);
        ch_trigger = '0;
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_start_en) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_wait: got no tx_start_en expected one within 400 cycles");
        end
    endtask

    task automatic serve(input int nreq, input bit done, output int dcyc);
        for (int i = 0; i < nreq; i++) begin
            @(negedge clk);
            tx_req = 1'b1;
        end
        @(negedge clk);
        tx_req = 1'b0;
        dcyc = -1;
        if (done) begin
            tx_done = 1'b1;
            dcyc = cyc;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        tx_req = 1'b0;
        tx_done = 1'b0;
        ch_trigger = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t0, s, s2, d, tc, snap0, snap1, snap2;
        logic [PB-1:0] p0, p1, p2, p3;
        rst_n = 1'b0;
        ch_payload = '0;
        ch_trigger = '0;
        tx_req = 1'b0;
        tx_done = 1'b0;
        fork
            monitor();
            counters();
        join_none
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(tx_start_en), 0);
        check("rst_data", tx_data, 0);
        check("rst_drop_cnt", {16'h0, drop_cnt}, 0);
        check("rst_ch_drop", {30'h0, ch_drop}, 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("byte_num", {16'h0, tx_byte_num}, 15);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single packet with one extra request past the last word
        p0 = 88'h0102030405060708090A0B;
        push_pkt(0, 16'h0000, p0, 5);
        trig(2'b01, p0, '0, t0);
        wait_start(s);
        check("t1_latency", s - t0, 2);
        serve(5, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);
        check("t1_idle", 32'(busy), 0);
        check("t1_data_hold", tx_data, 32'h090A0B00);

        // T2: simultaneous triggers, ch0 first then ch1; ch1 ended early by tx_done
        do_reset();
        p0 = 88'h11223344556677889900AA;
        p1 = 88'hCAFEBABE0123456789ABCD;
        snap0 = n_start;
        push_pkt(0, 16'h0000, p0, 4);
        push_pkt(1, 16'h0000, p1, 2);
        trig(2'b11, p0, p1, t0);
        wait_start(s);
        check("t2_latency", s - t0, 2);
        serve(4, 1'b1, d);
        wait_start(s2);
        check("t2_gap_min", 32'((s2 - d) >= GAP + 1), 1);
        check("t2_gap_max", 32'((s2 - d) <= GAP + 4), 1);
        serve(2, 1'b1, d);
        repeat (GAP + 20) @(negedge clk);
        check("t2_starts", n_start - snap0, 2);

        // T3: repeated triggers on a pending channel are dropped, first payload kept
        do_reset();
        snap0 = n_drop0;
        snap1 = n_drop1;
        p0 = 88'h0F0E0D0C0B0A0908070605;
        p1 = 88'h123456789ABCDEF0112233;
        p2 = 88'hDEADBEEFDEADBEEFDEADBE;
        push_pkt(0, 16'h0000, p0, 4);
        trig(2'b01, p0, '0, t0);
        wait_start(s);
        push_pkt(1, 16'h0000, p1, 4);
        trig(2'b10, '0, p1, t0);
        trig(2'b10, '0, p2, t0);
        trig(2'b10, '0, p2, t0);
        trig(2'b10, '0, p2, t0);
        repeat (2) @(negedge clk);
        check("t3_drop_cnt", {16'h0, drop_cnt}, 3);
        check("t3_drop1_pulses", n_drop1 - snap1, 3);
        check("t3_drop0_pulses", n_drop0 - snap0, 0);
        serve(4, 1'b1, d);
        wait_start(s);
        serve(4, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);

        // T4: ch0 times out, ch1 follows after the gap, ch0 sequence already advanced
        snap2 = n_tmo;
        p0 = 88'hA1A2A3A4A5A6A7A8A9AAAB;
        p1 = 88'hB1B2B3B4B5B6B7B8B9BABB;
        p3 = 88'hC1C2C3C4C5C6C7C8C9CACB;
        push_pkt(0, 16'h0001, p0, 2);
        push_pkt(1, 16'h0001, p1, 4);
        trig(2'b11, p0, p1, t0);
        wait_start(s);
        serve(2, 1'b0, d);
        tc = -1;
        for (int i = 0; i < TMO + 50; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                tc = cyc;
                break;
            end
        end
        check("t4_timeout_lo", 32'((tc - s) >= TMO), 1);
        check("t4_timeout_hi", 32'((tc - s) <= TMO + 2), 1);
        wait_start(s2);
        check("t4_gap_after_abort", 32'((s2 - tc) >= GAP + 1 && (s2 - tc) <= GAP + 3), 1);
        serve(4, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);
        push_pkt(0, 16'h0002, p3, 4);
        trig(2'b01, p3, '0, t0);
        wait_start(s);
        serve(4, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);
        check("t4_timeouts", n_tmo - snap2, 1);

        // T5: sequence wrap and drop counter saturation
        do_reset();
        force dut.r_seq = 32'h0000_FFFF;
        #1;
        release dut.r_seq;
        p0 = 88'h5A5A5A5A5A5A5A5A5A5A5A;
        push_pkt(0, 16'hFFFF, p0, 4);
        trig(2'b01, p0, '0, t0);
        wait_start(s);
        serve(4, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);
        push_pkt(0, 16'h0000, p0, 4);
        trig(2'b01, p0, '0, t0);
        wait_start(s);
        serve(4, 1'b1, d);
        repeat (GAP + 3) @(negedge clk);
        @(negedge clk);
        ch_trigger = 2'b11;
        repeat (34000) @(negedge clk);
        check("t5_drop_sat", {16'h0, drop_cnt}, 32'hFFFF);
        repeat (5) @(negedge clk);
        check("t5_drop_sat_hold", {16'h0, drop_cnt}, 32'hFFFF);
        ch_trigger = '0;

        // T6: reset in the middle of a packet
        do_reset();
        push_pkt(0, 16'h0000, p0, 1);
        trig(2'b01, p0, '0, t0);
        wait_start(s);
        serve(1, 1'b0, d);
        trig(2'b10, '0, p1, t0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_start", 32'(tx_start_en), 0);
        check("t6_data", tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        snap0 = n_start;
        repeat (60) @(negedge clk);
        check("t6_no_restart", n_start - snap0, 0);
        check("t6_idle", 32'(busy), 0);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
